// File: rtl/udp_rx.sv
// Receive-side UDP stage: parses the 8-byte header, filters on destination port, and re-packs the payload nibbles into bytes.
// Latency: hdr_valid and each payload byte are 1 cycle after their final beat. There is no backpressure, so every axiov beat must be taken.
module udp_rx #(
  parameter int          N           = 4,
  parameter logic [15:0] LISTEN_PORT = 16'd5001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] axiid,
  input  logic         axiiv,
  output logic [15:0]  src_port_out,
  output logic [15:0]  dst_port_out,
  output logic [15:0]  udp_length_out,
  output logic         hdr_valid,
  output logic [7:0]   axiod,
  output logic         axiov,
  output logic         axiolast,
  output logic         err
);

  localparam int HDR_BEATS  = 64 / N;
  localparam int BYTE_BEATS = 8 / N;

  typedef enum logic [2:0] {WAIT_LOW, IDLE, HEADER, PAYLOAD, DROP} state_t;

  state_t      state;
  logic [5:0]  beat_cnt;
  logic [1:0]  sub_cnt;
  logic [63:0] hdr_sr;
  logic [7:0]  byte_sr;
  logic [15:0] remaining;

  // Shift registers including the current beat, so the final beat is visible in the same cycle.
  logic [63:0] hdr_next;
  logic [7:0]  byte_next;
  logic [15:0] dst_next;
  logic [15:0] len_next;

  assign hdr_next  = {hdr_sr[63-N:0], axiid};
  assign byte_next = {byte_sr[7-N:0], axiid};
  assign dst_next  = hdr_next[47:32];
  assign len_next  = hdr_next[31:16];

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT_LOW;
      beat_cnt       <= '0;
      sub_cnt        <= '0;
      hdr_sr         <= '0;
      byte_sr        <= '0;
      remaining      <= '0;
      src_port_out   <= '0;
      dst_port_out   <= '0;
      udp_length_out <= '0;
      hdr_valid      <= 1'b0;
      axiod          <= '0;
      axiov          <= 1'b0;
      axiolast       <= 1'b0;
      err            <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      axiov     <= 1'b0;
      axiolast  <= 1'b0;
      err       <= 1'b0;
      case (state)
        WAIT_LOW: if (!axiiv) state <= IDLE;
        IDLE: begin
          if (axiiv) begin
            hdr_sr   <= hdr_next;
            beat_cnt <= 6'd1;
            state    <= HEADER;
          end
        end
        HEADER: begin
          if (!axiiv) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            hdr_sr   <= hdr_next;
            beat_cnt <= beat_cnt + 6'd1;
            if (beat_cnt == 6'(HDR_BEATS - 1)) begin
              src_port_out   <= hdr_next[63:48];
              dst_port_out   <= dst_next;
              udp_length_out <= len_next;
              if (len_next < 16'd8) begin
                err   <= 1'b1;
                state <= DROP;
              end else if (LISTEN_PORT != 16'd0 && dst_next != LISTEN_PORT) begin
                state <= DROP;
              end else begin
                hdr_valid <= 1'b1;
                remaining <= len_next - 16'd8;
                sub_cnt   <= '0;
                state     <= (len_next == 16'd8) ? DROP : PAYLOAD;
              end
            end
          end
        end
        PAYLOAD: begin
          // A short datagram never emits its partial byte.
          if (!axiiv) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            byte_sr <= byte_next;
            sub_cnt <= sub_cnt + 2'd1;
            if (sub_cnt == 2'(BYTE_BEATS - 1)) begin
              sub_cnt   <= '0;
              axiod     <= byte_next;
              axiov     <= 1'b1;
              remaining <= remaining - 16'd1;
              if (remaining == 16'd1) begin
                axiolast <= 1'b1;
                state    <= DROP;
              end
            end
          end
        end
        DROP: if (!axiiv) state <= IDLE;
        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule
